// File: rtl/rob_ring_pkg.sv
// Shared definitions for the reorder buffer: entry type encodings and the
// normalisation applied to incoming type codes.
package rob_ring_pkg;

    localparam logic [1:0] ROB_TYPE_REG   = 2'd0;
    localparam logic [1:0] ROB_TYPE_STORE = 2'd1;
    localparam logic [1:0] ROB_TYPE_LOAD  = 2'd2;

    // Code 3 is unassigned and is stored as a plain register write.
    function automatic logic [1:0] rob_type_norm(input logic [1:0] t);
        return (t == 2'd3) ? ROB_TYPE_REG : t;
    endfunction

endpackage

// File: rtl/rob_ring_lane_prefix_count.sv
// Exclusive prefix popcount over a small lane mask.
// cnt[i] = number of set bits in bits[i-1:0]; cnt[WIDTH] is the total.
module lane_prefix_count #(
    parameter int WIDTH = 2,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]         bits,
    output logic [WIDTH:0][CW-1:0]   cnt
);

    logic [CW-1:0] acc;

    // Ripple the running count across the lanes.
    always_comb begin
        acc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt[i] = acc;
            acc    = acc + CW'(bits[i]);
        end
        cnt[WIDTH] = acc;
    end

endmodule

// File: rtl/rob_ring.sv
// Multi-lane ring reorder buffer: compacted in-order allocation, out-of-order
// completion writeback from NUM_FU ports, in-order retire of up to WIDTH
// completed entries per cycle, and a full flush.
module rob_ring
    import rob_ring_pkg::*;
#(
    parameter  int DEPTH  = 16,
    parameter  int WIDTH  = 2,
    parameter  int NUM_FU = 3,
    parameter  int AREG_W = 5,
    parameter  int PREG_W = 6,
    parameter  int DATA_W = 32,
    localparam int IDX_W  = $clog2(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            alloc_valid,
    input  logic [2*WIDTH-1:0]          alloc_type,
    input  logic [AREG_W*WIDTH-1:0]     alloc_areg,
    input  logic [PREG_W*WIDTH-1:0]     alloc_preg,
    input  logic [PREG_W*WIDTH-1:0]     alloc_old_preg,
    output logic                        alloc_ready,
    output logic [IDX_W*WIDTH-1:0]      alloc_idx,
    input  logic [NUM_FU-1:0]           cmp_valid,
    input  logic [IDX_W*NUM_FU-1:0]     cmp_idx,
    input  logic [DATA_W*NUM_FU-1:0]    cmp_result,
    input  logic                        flush,
    output logic [WIDTH-1:0]            ret_valid,
    output logic [2*WIDTH-1:0]          ret_type,
    output logic [AREG_W*WIDTH-1:0]     ret_areg,
    output logic [PREG_W*WIDTH-1:0]     ret_preg,
    output logic [PREG_W*WIDTH-1:0]     ret_old_preg,
    output logic [DATA_W*WIDTH-1:0]     ret_result,
    output logic [IDX_W:0]              count,
    output logic                        empty,
    output logic                        full
);

    localparam int PW = IDX_W + 1;
    localparam int CW = $clog2(WIDTH + 1);

    // Ring pointers; the MSB is the wrap bit that separates full from empty.
    logic [PW-1:0] head, tail;

    // Per-field entry storage.
    logic [DEPTH-1:0]              ent_v;
    logic [DEPTH-1:0]              ent_comp;
    logic [DEPTH-1:0][1:0]         ent_type;
    logic [DEPTH-1:0][AREG_W-1:0]  ent_areg;
    logic [DEPTH-1:0][PREG_W-1:0]  ent_preg;
    logic [DEPTH-1:0][PREG_W-1:0]  ent_old_preg;
    logic [DEPTH-1:0][DATA_W-1:0]  ent_result;

    // ------------------------------------------------------------------
    // Occupancy. alloc_ready ignores same-cycle retires on purpose so the
    // ready path does not depend on the retire scan.
    // ------------------------------------------------------------------
    assign count       = tail - head;
    assign empty       = (count == '0);
    assign full        = (count == PW'(DEPTH));
    assign alloc_ready = ((PW'(DEPTH) - count) >= PW'(WIDTH));

    // ------------------------------------------------------------------
    // Allocation: valid lanes are packed onto consecutive slots from tail.
    // ------------------------------------------------------------------
    logic [WIDTH:0][CW-1:0]       alloc_cnt;
    logic [WIDTH-1:0][IDX_W-1:0]  alloc_slot;
    logic                         alloc_fire;

    lane_prefix_count #(.WIDTH(WIDTH)) u_alloc_cnt (
        .bits (alloc_valid),
        .cnt  (alloc_cnt)
    );

    assign alloc_fire = alloc_ready && (|alloc_valid);

    for (genvar i = 0; i < WIDTH; i++) begin : g_alloc_lane
        assign alloc_slot[i]                 = tail[IDX_W-1:0] + IDX_W'(alloc_cnt[i]);
        assign alloc_idx[i*IDX_W +: IDX_W]   = alloc_slot[i];
    end

    // ------------------------------------------------------------------
    // Completion port decode.
    // ------------------------------------------------------------------
    logic [NUM_FU-1:0][IDX_W-1:0]  cmp_slot;
    logic [NUM_FU-1:0][DATA_W-1:0] cmp_data;

    for (genvar k = 0; k < NUM_FU; k++) begin : g_cmp_port
        assign cmp_slot[k] = cmp_idx[k*IDX_W +: IDX_W];
        assign cmp_data[k] = cmp_result[k*DATA_W +: DATA_W];
    end

    // ------------------------------------------------------------------
    // Retire scan from registered state: the leading run of done entries
    // starting at head, capped at WIDTH.
    // ------------------------------------------------------------------
    logic [WIDTH-1:0][IDX_W-1:0]  ret_slot;
    logic [WIDTH-1:0]             ret_ok;
    logic [WIDTH:0][CW-1:0]       ret_cnt;
    logic [CW-1:0]                n_ret;
    logic [WIDTH-1:0]             ret_take;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ret_lane
        assign ret_slot[i] = head[IDX_W-1:0] + IDX_W'(i);
        assign ret_ok[i]   = ent_v[ret_slot[i]] && ent_comp[ret_slot[i]];
        assign ret_take[i] = (CW'(i) < n_ret);
    end

    lane_prefix_count #(.WIDTH(WIDTH)) u_ret_cnt (
        .bits (ret_ok),
        .cnt  (ret_cnt)
    );

    // The run length is the largest i whose prefix count equals i, i.e.
    // every lane below i qualified.
    always_comb begin
        n_ret = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            if (ret_cnt[i] == CW'(i)) n_ret = CW'(i);
        end
    end

    // ------------------------------------------------------------------
    // State updates.
    // ------------------------------------------------------------------

    // Ring pointers advance by accepted allocations and retired entries.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            tail <= tail + (alloc_fire ? PW'(alloc_cnt[WIDTH]) : PW'(0));
            head <= head + PW'(n_ret);
        end
    end

    // Entry array: allocate, then completion writeback, then retire clear.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_v <= '0;
        end else begin
            if (alloc_fire) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (alloc_valid[i]) begin
                        ent_v[alloc_slot[i]]        <= 1'b1;
                        ent_comp[alloc_slot[i]]     <= 1'b0;
                        ent_type[alloc_slot[i]]     <= rob_type_norm(alloc_type[i*2 +: 2]);
                        ent_areg[alloc_slot[i]]     <= alloc_areg[i*AREG_W +: AREG_W];
                        ent_preg[alloc_slot[i]]     <= alloc_preg[i*PREG_W +: PREG_W];
                        ent_old_preg[alloc_slot[i]] <= alloc_old_preg[i*PREG_W +: PREG_W];
                    end
                end
            end
            // Higher-numbered ports are visited last, so they win a collision.
            for (int k = 0; k < NUM_FU; k++) begin
                if (cmp_valid[k] && ent_v[cmp_slot[k]]) begin
                    ent_comp[cmp_slot[k]]   <= 1'b1;
                    ent_result[cmp_slot[k]] <= cmp_data[k];
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (ret_take[i]) ent_v[ret_slot[i]] <= 1'b0;
            end
        end
    end

    // Registered retire outputs; fields are zeroed on idle lanes.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ret_valid    <= '0;
            ret_type     <= '0;
            ret_areg     <= '0;
            ret_preg     <= '0;
            ret_old_preg <= '0;
            ret_result   <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                ret_valid[i]                      <= ret_take[i];
                ret_type[i*2 +: 2]                <= ret_take[i] ? ent_type[ret_slot[i]]     : '0;
                ret_areg[i*AREG_W +: AREG_W]      <= ret_take[i] ? ent_areg[ret_slot[i]]     : '0;
                ret_preg[i*PREG_W +: PREG_W]      <= ret_take[i] ? ent_preg[ret_slot[i]]     : '0;
                ret_old_preg[i*PREG_W +: PREG_W]  <= ret_take[i] ? ent_old_preg[ret_slot[i]] : '0;
                ret_result[i*DATA_W +: DATA_W]    <= ret_take[i] ? ent_result[ret_slot[i]]   : '0;
            end
        end
    end

endmodule
